// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared constants and saturating accumulator helper for the scanline buffer
package video_pkg;
  localparam int SCALE_FRAC = 7;
  localparam int LINE_W     = 640;
  localparam int IDX_W      = 8;
  localparam int ACC_W      = 18;
  localparam int ADDR_W     = 10;
  localparam int RD_W       = ACC_W - SCALE_FRAC;

  // Saturate rather than wrap so an overscaled line stays in the border region.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc, input logic [7:0] step);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + {{(ACC_W-7){1'b0}}, step};
    return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  endfunction
endpackage

// File: rtl/video_line_bank.sv
// rtl/video_line_bank.sv - one scanline bank: simple dual-port RAM, sync read with enable
module video_line_bank
  import video_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [IDX_W-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [IDX_W-1:0]  o_rdata
);
  logic [IDX_W-1:0] r_mem [LINE_W];
  logic [IDX_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;
endmodule

// File: rtl/video_line_buffer.sv
// rtl/video_line_buffer.sv - ping-pong scanline buffer with fixed-point scaling and border fill
module video_line_buffer
  import video_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pix_en,
  input  logic              i_next_frame,
  input  logic              i_next_line,
  input  logic              i_next_pixel,
  input  logic [7:0]        i_hscale,
  input  logic [7:0]        i_vscale,
  input  logic [IDX_W-1:0]  i_border_idx,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [IDX_W-1:0]  i_wr_data,
  output logic              o_line_req,
  output logic [ADDR_W-1:0] o_render_line,
  output logic [IDX_W-1:0]  o_pal_idx
);
  logic              r_disp_sel;
  logic [ACC_W-1:0]  r_x_acc;
  logic [ACC_W-1:0]  r_y_acc;
  logic              r_line_req;
  logic [ADDR_W-1:0] r_render_line;
  logic              r_has_data;
  logic              r_border;
  logic              r_rd_bank;
  logic [IDX_W-1:0]  r_border_val;

  logic              w_tick;
  logic              w_pix;
  logic              w_border;
  logic              w_wr_ok;
  logic [RD_W-1:0]   w_rd_addr;
  logic [ACC_W-1:0]  w_y_next;
  logic [IDX_W-1:0]  w_q0;
  logic [IDX_W-1:0]  w_q1;

  always_comb begin
    w_tick    = i_pix_en & i_next_line;
    w_pix     = i_pix_en & i_next_pixel;
    w_rd_addr = r_x_acc[ACC_W-1:SCALE_FRAC];
    w_border  = (w_rd_addr >= RD_W'(LINE_W));
    w_wr_ok   = i_wr_en & ~rst & (i_wr_addr < ADDR_W'(LINE_W));
    w_y_next  = i_next_frame ? '0 : sat_add(r_y_acc, i_vscale);
  end

  // Render writes go to the bank not on display; reads only from the displayed one.
  video_line_bank u_bank0 (
    .clk     (clk),
    .i_we    (w_wr_ok & r_disp_sel),
    .i_waddr (i_wr_addr),
    .i_wdata (i_wr_data),
    .i_re    (w_pix & ~w_border & ~r_disp_sel),
    .i_raddr (w_rd_addr[ADDR_W-1:0]),
    .o_rdata (w_q0)
  );

  video_line_bank u_bank1 (
    .clk     (clk),
    .i_we    (w_wr_ok & ~r_disp_sel),
    .i_waddr (i_wr_addr),
    .i_wdata (i_wr_data),
    .i_re    (w_pix & ~w_border & r_disp_sel),
    .i_raddr (w_rd_addr[ADDR_W-1:0]),
    .o_rdata (w_q1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp_sel    <= 1'b0;
      r_x_acc       <= '0;
      r_y_acc       <= '0;
      r_line_req    <= 1'b0;
      r_render_line <= '0;
      r_has_data    <= 1'b0;
      r_border      <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_border_val  <= '0;
    end else begin
      r_line_req <= w_tick;
      if (w_tick) begin
        r_disp_sel    <= ~r_disp_sel;
        r_x_acc       <= '0;
        r_y_acc       <= w_y_next;
        r_render_line <= w_y_next[ADDR_W+SCALE_FRAC-1:SCALE_FRAC];
      end else if (w_pix) begin
        r_x_acc <= sat_add(r_x_acc, i_hscale);
      end
      // Output select is captured alongside the RAM read so both land on the same edge.
      if (w_pix) begin
        r_has_data   <= 1'b1;
        r_border     <= w_border;
        r_rd_bank    <= r_disp_sel;
        r_border_val <= i_border_idx;
      end
    end
  end

  always_comb begin
    if (!r_has_data)    o_pal_idx = '0;
    else if (r_border)  o_pal_idx = r_border_val;
    else if (r_rd_bank) o_pal_idx = w_q1;
    else                o_pal_idx = w_q0;
  end

  assign o_line_req    = r_line_req;
  assign o_render_line = r_render_line;
endmodule

// File: tb/tb_video_line_buffer.sv
// tb/tb_video_line_buffer.sv - self-checking bench for video_line_buffer
module tb_video_line_buffer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_en = 1'b0;
  logic       next_frame = 1'b0;
  logic       next_line = 1'b0;
  logic       next_pixel = 1'b0;
  logic [7:0] hscale = 8'd128;
  logic [7:0] vscale = 8'd128;
  logic [7:0] border_idx = 8'h3F;
  logic       wr_en = 1'b0;
  logic [9:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       line_req;
  logic [9:0] render_line;
  logic [7:0] pal_idx;

  int vectors = 0;
  int miscompares = 0;

  video_line_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .i_pix_en      (pix_en),
    .i_next_frame  (next_frame),
    .i_next_line   (next_line),
    .i_next_pixel  (next_pixel),
    .i_hscale      (hscale),
    .i_vscale      (vscale),
    .i_border_idx  (border_idx),
    .i_wr_en       (wr_en),
    .i_wr_addr     (wr_addr),
    .i_wr_data     (wr_data),
    .o_line_req    (line_req),
    .o_render_line (render_line),
    .o_pal_idx     (pal_idx)
  );

  always #5 clk = ~clk;

  // Model: pixel n of a line reads floor(min(n*hscale, 2^18-1) / 128); line m of a frame renders min(m*vscale, 2^18-1) / 128.
  logic [7:0] mbank [2][640];
  int         m_disp, m_n, m_m;
  logic       m_req;
  logic [9:0] m_render;
  logic [7:0] m_pal;

  always @(posedge clk) begin
    longint x, y;
    int     addr;
    if (rst) begin
      m_disp = 0; m_n = 0; m_m = 0;
      m_req = 1'b0; m_render = '0; m_pal = '0;
    end else begin
      if (wr_en && wr_addr < 10'd640) mbank[1-m_disp][wr_addr] = wr_data;
      if (pix_en && next_pixel) begin
        x = longint'(m_n) * longint'(hscale);
        if (x > 262143) x = 262143;
        addr  = int'(x / 128);
        m_pal = (addr < 640) ? mbank[m_disp][addr] : border_idx;
        m_n++;
      end
      m_req = pix_en && next_line;
      if (pix_en && next_line) begin
        m_disp = 1 - m_disp;
        m_n    = 0;
        if (next_frame) m_m = 0;
        else m_m++;
        y = longint'(m_m) * longint'(vscale);
        if (y > 262143) y = 262143;
        m_render = 10'(y / 128);
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 20)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("line_req", 32'(line_req), 32'(m_req));
    cmp("render_line", 32'(render_line), 32'(m_render));
    cmp("pal_idx", 32'(pal_idx), 32'(m_pal));
  end

  task automatic tick(input logic frame);
    @(negedge clk);
    pix_en = 1'b1; next_line = 1'b1; next_frame = frame; next_pixel = 1'b0;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  task automatic pixel();
    @(negedge clk);
    pix_en = 1'b1; next_pixel = 1'b1; next_line = 1'b0; next_frame = 1'b0;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 10'(a); wr_data = 8'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic fill(input logic invert);
    for (int i = 0; i < 640; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 10'(i); wr_data = invert ? ~8'(i) : 8'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp_rl [4] = '{0, 1, 1, 2};
    repeat (3) @(negedge clk);
    cmp("reset_pal", 32'(pal_idx), 0);
    cmp("reset_req", 32'(line_req), 0);
    cmp("reset_rline", 32'(render_line), 0);
    rst = 1'b0;

    fill(1'b0);
    tick(1'b1);
    cmp("first_req", 32'(line_req), 1);
    cmp("first_rline", 32'(render_line), 0);
    fill(1'b1);
    wr(5, 8'hAA);
    wr(700, 8'h55);

    for (int i = 0; i < 800; i++) begin
      pixel();
      if (i == 0)   cmp("h1_px0", 32'(pal_idx), 0);
      if (i == 5)   cmp("h1_px5_unchanged", 32'(pal_idx), 5);
      if (i == 255) cmp("h1_px255", 32'(pal_idx), 255);
      if (i == 256) cmp("h1_px256", 32'(pal_idx), 0);
      if (i == 300) cmp("h1_px300", 32'(pal_idx), 32'h2C);
      if (i == 383) cmp("h1_px383", 32'(pal_idx), 32'h7F);
      if (i == 639) cmp("h1_px639", 32'(pal_idx), 32'h7F);
      if (i == 640) cmp("h1_border640", 32'(pal_idx), 32'h3F);
      if (i == 799) cmp("h1_border799", 32'(pal_idx), 32'h3F);
    end

    tick(1'b0);
    cmp("line2_rline", 32'(render_line), 1);
    for (int i = 0; i <= 300; i++) begin
      pixel();
      if (i == 4) cmp("swap_px4", 32'(pal_idx), 32'hFB);
      if (i == 5) cmp("swap_px5_written", 32'(pal_idx), 32'hAA);
    end

    @(negedge clk);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 10'd5; wr_data = 8'h11;
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0;
    cmp("midrst_pal", 32'(pal_idx), 0);
    cmp("midrst_req", 32'(line_req), 0);
    cmp("midrst_rline", 32'(render_line), 0);

    hscale = 8'd64; vscale = 8'd64;
    tick(1'b1);
    cmp("postrst_req", 32'(line_req), 1);
    cmp("postrst_rline", 32'(render_line), 0);
    for (int i = 0; i < 12; i++) begin
      pixel();
      if (i == 1)  cmp("half_px1", 32'(pal_idx), 0);
      if (i == 2)  cmp("half_px2", 32'(pal_idx), 1);
      if (i == 5)  cmp("half_px5", 32'(pal_idx), 2);
      if (i == 10) cmp("half_px10_dropped_wr", 32'(pal_idx), 5);
    end
    for (int k = 0; k < 4; k++) begin
      tick(1'b0);
      cmp("vhalf_rline", 32'(render_line), 32'(exp_rl[k]));
    end

    hscale = 8'd255;
    tick(1'b0);
    for (int i = 0; i < 1100; i++) begin
      pixel();
      if (i == 321)  cmp("h255_px321", 32'(pal_idx), 32'h80);
      if (i == 322)  cmp("h255_px322", 32'(pal_idx), 32'h3F);
      if (i == 799)  cmp("h255_px799", 32'(pal_idx), 32'h3F);
      if (i == 1099) cmp("h255_sat_nowrap", 32'(pal_idx), 32'h3F);
    end

    hscale = 8'd128;
    tick(1'b1);
    cmp("frame_req", 32'(line_req), 1);
    cmp("frame_rline", 32'(render_line), 0);
    @(negedge clk);
    cmp("frame_req_single", 32'(line_req), 0);
    for (int i = 0; i < 6; i++) begin
      pixel();
      if (i == 1) cmp("frame_swap_px1", 32'(pal_idx), 1);
      if (i == 5) cmp("frame_swap_px5", 32'(pal_idx), 5);
    end

    vscale = 8'd0;
    tick(1'b0);
    tick(1'b0);
    cmp("vzero_rline", 32'(render_line), 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
